sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Result drain for the N×N systolic matmul array. Snapshots the array's flat accumulator bus when the compute controller signals results are final. Re-quantizes each ACC_WIDTH accumulator to OUT_WIDTH and streams the N·N elements row-major over a valid/ready interface to the writeback path. Sits directly downstream of the systolic array's packed output, so the array is free to start the next tile while the drain empties.

## Interface
- N, 4, array dimension (N×N elements per tile)
- ACC_WIDTH, 32, accumulator width of each input element (signed two's complement)
- OUT_WIDTH, 8, streamed element width
- SHIFT, 8, arithmetic right-shift applied before narrowing (0 ≤ SHIFT < ACC_WIDTH)
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- capture  in  1  one-cycle strobe: in_flat holds final results this cycle
- in_flat  in  N*N*ACC_WIDTH  element (i,j) at bits [(i*N+j)*ACC_WIDTH +: ACC_WIDTH]
- cap_ready  out  1  high when a capture will be accepted
- busy  out  1  high while a tile is being streamed
- m_valid  out  1  output element valid
- m_ready  in  1  downstream accepts
- m_data  out  OUT_WIDTH  re-quantized element
- m_row  out  $clog2(N)  row index of m_data
- m_col  out  $clog2(N)  column index of m_data
- m_last  out  1  high with element (N-1,N-1)
- overrun  out  1  sticky: capture arrived while not cap_ready
- sat_flag  out  1  sticky: at least one element clamped in the current or last tile

## Operation
- FSM states: IDLE, STREAM.
- IDLE: cap_ready=1, busy=0, m_valid=0. On capture, register in_flat into the snapshot, set row=col=0, clear sat_flag, and go to STREAM.
- STREAM: cap_ready=0, busy=1, m_valid=1. m_data/m_row/m_col/m_last are registered and held stable until the handshake (m_valid && m_ready).
- On each handshake, col increments; when col wraps N-1→0, row increments.
- Handshake on element (N-1,N-1) (m_last=1) → IDLE.
- Capture while not in IDLE (including the final-handshake cycle) is dropped. It sets overrun. The stream and snapshot are unaffected.
- Requant: v = snapshot(i,j) >>> SHIFT (arithmetic).
  - Without saturation: m_data = v[OUT_WIDTH-1:0].
  - Saturation behaviour is under Configuration.
- overrun and sat_flag are cleared only by rst. sat_flag is additionally cleared on an accepted capture.

## Timing
- Reset values: cap_ready=1; busy, m_valid, m_data, m_row, m_col, m_last, overrun, sat_flag all 0; state IDLE.
- rst mid-stream aborts the tile: the next cycle shows reset values, and the snapshot contents are don't-care.
- Latency: capture sampled at edge k → m_valid=1 with element (0,0) after edge k, valid in cycle k+1.
- Throughput: one element per cycle with m_ready held high; a tile drains in N·N cycles.
- After the final handshake at edge t, cap_ready=1 in cycle t+1. Minimum capture-to-capture spacing is N·N+1 cycles.
- Backpressure: while m_valid && !m_ready, all m_* outputs hold their values exactly.
- sat_flag updates in the same cycle the clamped element is presented on m_data.

## Configuration
- Macro: SA_DRAIN_SAT_EN.
- Defined: v is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before narrowing. Any clamp sets sat_flag.
- Undefined: plain truncation of v, and sat_flag is tied to 0.

## Structure
- Shared package sa_pkg:
  - drain state enum (IDLE, STREAM)
  - index width localparam helper ($clog2(N) with a minimum of 1)
  - element-slice function (i, j) → flat bit offset, also usable by the array and the controller
- One sub-module, sa_requant: combinational shift plus optional clamp. It is parameterized by ACC_WIDTH, OUT_WIDTH and SHIFT, outputs data and a clamp bit, and honours SA_DRAIN_SAT_EN.

## Test plan
- Reset: assert rst 2 cycles → all outputs at reset values, cap_ready=1. A capture in the same cycle as rst is ignored.
- Basic stream (N=4, SHIFT=8, OUT_WIDTH=8, m_ready=1): element (i,j)=(i*4+j)<<8 → 16 consecutive beats with m_data 0..15, m_row/m_col row-major, m_last only on beat 16, cap_ready=1 the cycle after.
- Backpressure: same tile, m_ready pattern 1,0,0,1,0,1,… → every element appears exactly once and in order, and outputs are stable across stall cycles.
- Saturation: element (0,0)=0x00010000 and (0,1)=0xFFFF0000.
  - With SA_DRAIN_SAT_EN: m_data 0x7F then 0x80, sat_flag=1 from beat 1.
  - Without: 0x00 and 0x00, sat_flag=0.
  - Element 0x00007F00 gives 0x7F in both builds.
- Overrun: capture pulses at beats 3 and 16 (final-handshake cycle) → overrun=1, the tile completes unchanged, and no second tile is streamed.
- Reset mid-stream: rst after beat 5 → next cycle m_valid=0, overrun=0, cap_ready=1. A fresh capture then streams from (0,0).

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array slice: drain FSM states, index
// width helper and the flat-bus element offset used by array, controller and drain.
package sa_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    // Row/column index width; never zero so a 1x1 array still gets a port bit.
    function automatic int sa_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sa_elem_off(input int i, input int j, input int n, input int w);
        return (i * n + j) * w;
    endfunction

endpackage

// File: rtl/sa_requant.sv
// Combinational re-quantizer: arithmetic right shift then narrowing.
// Clamping to the signed OUT_WIDTH range is enabled by SA_DRAIN_SAT_EN.
module sa_requant #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic        [OUT_WIDTH-1:0] data,
    output logic                        clamp
);

    logic signed [ACC_WIDTH-1:0] v;

    assign v = acc >>> SHIFT;

`ifdef SA_DRAIN_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        data  = v[OUT_WIDTH-1:0];
        clamp = 1'b0;
        if (v > SAT_MAX) begin
            data  = SAT_MAX[OUT_WIDTH-1:0];
            clamp = 1'b1;
        end else if (v < SAT_MIN) begin
            data  = SAT_MIN[OUT_WIDTH-1:0];
            clamp = 1'b1;
        end
    end
`else
    // Plain truncation discards the high bits of the shifted value.
    logic unused_hi;
    assign unused_hi = ^v[ACC_WIDTH-1:OUT_WIDTH];

    always_comb begin
        data  = v[OUT_WIDTH-1:0];
        clamp = 1'b0;
    end
`endif

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the array accumulator bus on capture and streams re-quantized
// elements row-major over valid/ready. Saturation build option: SA_DRAIN_SAT_EN.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 8,
    localparam int IDX_W    = sa_idx_w(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture,
    input  logic [N*N*ACC_WIDTH-1:0]   in_flat,
    output logic                       cap_ready,
    output logic                       busy,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_WIDTH-1:0]       m_data,
    output logic [IDX_W-1:0]           m_row,
    output logic [IDX_W-1:0]           m_col,
    output logic                       m_last,
    output logic                       overrun,
    output logic                       sat_flag,
    output drain_state_e               dbg_state
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    // Handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // m_* are registered and hold until that edge.
    drain_state_e               state_q, state_d;
    logic [N*N*ACC_WIDTH-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]           row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]           nxt_row, nxt_col;
    logic [OUT_WIDTH-1:0]       data_q, data_d;
    logic                       last_q, last_d;
    logic                       overrun_q, overrun_d;
    logic                       sat_q, sat_d;
    logic                       handshake;
    int                         nxt_idx;
    logic signed [ACC_WIDTH-1:0] rq_acc;
    logic [OUT_WIDTH-1:0]       rq_data;
    logic                       rq_clamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            data_q    <= data_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
        end
    end

    // Snapshot contents are meaningless after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    always_comb begin
        nxt_row = row_q;
        nxt_col = col_q + 1'b1;
        if (col_q == IDX_MAX) begin
            nxt_col = '0;
            nxt_row = row_q + 1'b1;
        end
        nxt_idx = int'(nxt_row) * N + int'(nxt_col);
    end

    // The first beat is re-quantized straight from the bus so it is ready
    // the cycle after capture; later beats come from the snapshot.
    always_comb begin
        rq_acc = in_flat[ACC_WIDTH-1:0];
        if (state_q == STREAM) begin
            for (int k = 0; k < N * N; k++) begin
                if (k == nxt_idx) begin
                    rq_acc = snap_q[sa_elem_off(k / N, k % N, N, ACC_WIDTH) +: ACC_WIDTH];
                end
            end
        end
    end

    sa_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc   (rq_acc),
        .data  (rq_data),
        .clamp (rq_clamp)
    );

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        row_d     = row_q;
        col_d     = col_q;
        data_d    = data_q;
        last_d    = last_q;
        sat_d     = sat_q;
        overrun_d = overrun_q | (capture & (state_q != IDLE));
        handshake = (state_q == STREAM) && m_ready;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                    snap_d  = in_flat;
                    row_d   = '0;
                    col_d   = '0;
                    data_d  = rq_data;
                    last_d  = (N == 1);
                    sat_d   = rq_clamp;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (last_q) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        row_d  = nxt_row;
                        col_d  = nxt_col;
                        data_d = rq_data;
                        last_d = (nxt_row == IDX_MAX) && (nxt_col == IDX_MAX);
                        sat_d  = sat_q | rq_clamp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_ready = (state_q == IDLE);
        busy      = (state_q == STREAM);
        m_valid   = (state_q == STREAM);
        m_data    = data_q;
        m_row     = row_q;
        m_col     = col_q;
        m_last    = last_q;
        overrun   = overrun_q;
        sat_flag  = sat_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: a tile-level model builds the expected
// beat sequence, a negedge monitor checks every transfer and every stall.
module tb_sa_result_drain;
    import sa_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int SH = 8;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 capture = 1'b0;
    logic                 m_ready = 1'b1;
    logic [N*N*AW-1:0]    in_flat = '0;
    logic                 cap_ready, busy, m_valid, m_last, overrun, sat_flag;
    logic [OW-1:0]        m_data;
    logic [IW-1:0]        m_row, m_col;
    drain_state_e         dbg_state;

    sa_result_drain #(.N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .in_flat   (in_flat),
        .cap_ready (cap_ready),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_col     (m_col),
        .m_last    (m_last),
        .overrun   (overrun),
        .sat_flag  (sat_flag),
        .dbg_state (dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic [IW-1:0] r;
        logic [IW-1:0] c;
        logic          l;
        logic          s;
    } beat_t;

    beat_t         exp_q[$];
    logic [OW-1:0] rx_q[$];
    logic          rx_last_q[$];
    logic [AW-1:0] tile [N][N];
    int            vectors = 0;
    int            miscompares = 0;
    bit            bp_en = 1'b0;
    int            bp_idx = 0;
    bit            ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the tile must look like on the stream, from the tile contents.
    task automatic load_tile();
        bit            s;
        int            v;
        logic [OW-1:0] d;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                in_flat[(i*N+j)*AW +: AW] = tile[i][j];
                v = $signed(tile[i][j]) >>> SH;
`ifdef SA_DRAIN_SAT_EN
                if (v > 127) begin
                    d = 8'h7F;
                    s = 1'b1;
                end else if (v < -128) begin
                    d = 8'h80;
                    s = 1'b1;
                end else begin
                    d = v[7:0];
                end
`else
                d = v[7:0];
`endif
                exp_q.push_back('{d: d, r: IW'(i), c: IW'(j), l: (i == N-1 && j == N-1), s: s});
            end
        end
    endtask

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
        if (bp_en) begin
            m_ready = ready_pat[bp_idx];
            bp_idx  = (bp_idx + 1) % 6;
        end
    endtask

    task automatic send_tile();
        rx_q.delete();
        rx_last_q.delete();
        load_tile();
        capture = 1'b1;
        cycle();
        capture = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle();
            #1;
            n++;
        end
        check({name, "_timeout"}, 32'(n < 300), 32'd1);
        check({name, "_cap_ready_after"}, 32'(cap_ready), 32'd1);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_rx_seq(input string name);
        check({name, "_beat_count"}, 32'(rx_q.size()), 32'd16);
        for (int k = 0; k < rx_q.size(); k++) begin
            check({name, "_lit_data"}, 32'(rx_q[k]), 32'(k));
            check({name, "_lit_last"}, 32'(rx_last_q[k]), 32'(k == 15));
        end
    endtask

    task automatic fill_counting_tile();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                tile[i][j] = 32'(i * 4 + j) << 8;
    endtask

    // scoreboard / monitor
    logic          stall_prev = 1'b0;
    logic [OW-1:0] p_d;
    logic [IW-1:0] p_r, p_c;
    logic          p_l;
    beat_t         cur;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(p_d));
                check("hold_row", 32'(m_row), 32'(p_r));
                check("hold_col", 32'(m_col), 32'(p_c));
                check("hold_last", 32'(m_last), 32'(p_l));
            end
            if (m_valid && exp_q.size() == 0) begin
                check("spurious_valid", 32'(m_valid), 32'd0);
            end else if (m_valid && m_ready) begin
                cur = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(cur.d));
                check("beat_row", 32'(m_row), 32'(cur.r));
                check("beat_col", 32'(m_col), 32'(cur.c));
                check("beat_last", 32'(m_last), 32'(cur.l));
                check("beat_sat", 32'(sat_flag), 32'(cur.s));
                rx_q.push_back(m_data);
                rx_last_q.push_back(m_last);
            end
            stall_prev = m_valid && !m_ready;
            p_d = m_data;
            p_r = m_row;
            p_c = m_col;
            p_l = m_last;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles with a capture in the first one.
        fill_counting_tile();
        for (int k = 0; k < N*N; k++) in_flat[k*AW +: AW] = tile[k/N][k%N];
        rst = 1'b1;
        capture = 1'b1;
        cycle();
        capture = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_cap_ready", 32'(cap_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_row", 32'(m_row), 32'd0);
        check("rst_m_col", 32'(m_col), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        cycle();
        check("rst_capture_ignored", 32'(m_valid), 32'd0);

        // Basic stream with m_ready held high.
        send_tile();
        check("basic_first_beat_valid", 32'(m_valid), 32'd1);
        wait_drain("basic");
        check_rx_seq("basic");

        // Same tile under a 1,0,0,1,0,1 ready pattern.
        bp_en = 1'b1;
        bp_idx = 0;
        send_tile();
        wait_drain("bp");
        check_rx_seq("bp");
        bp_en = 1'b0;
        m_ready = 1'b1;

        // Saturation corner elements.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                tile[i][j] = '0;
        tile[0][0] = 32'h0001_0000;
        tile[0][1] = 32'hFFFF_0000;
        tile[0][2] = 32'h0000_7F00;
        send_tile();
        wait_drain("sat");
`ifdef SA_DRAIN_SAT_EN
        check("sat_lit_e00", 32'(rx_q[0]), 32'h7F);
        check("sat_lit_e01", 32'(rx_q[1]), 32'h80);
        check("sat_lit_flag", 32'(sat_flag), 32'd1);
`else
        check("sat_lit_e00", 32'(rx_q[0]), 32'h00);
        check("sat_lit_e01", 32'(rx_q[1]), 32'h00);
        check("sat_lit_flag", 32'(sat_flag), 32'd0);
`endif
        check("sat_lit_e02", 32'(rx_q[2]), 32'h7F);

        // A fresh capture clears sat_flag.
        fill_counting_tile();
        send_tile();
        wait_drain("basic2");
        check("basic2_sat_flag", 32'(sat_flag), 32'd0);

        // Captures at beat 3 and at the final-handshake beat are dropped.
        send_tile();
        cycle();
        cycle();
        capture = 1'b1;
        in_flat = '1;
        cycle();
        capture = 1'b0;
        repeat (12) cycle();
        check("ovr_last_presented", 32'(m_last), 32'd1);
        capture = 1'b1;
        cycle();
        capture = 1'b0;
        check("ovr_cap_ready_after", 32'(cap_ready), 32'd1);
        check("ovr_overrun", 32'(overrun), 32'd1);
        check("ovr_all_beats", 32'(exp_q.size()), 32'd0);
        check_rx_seq("ovr");
        repeat (8) cycle();
        check("ovr_no_second_tile", 32'(m_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset after five beats, then a fresh tile.
        send_tile();
        repeat (5) cycle();
        rst = 1'b1;
        exp_q.delete();
        cycle();
        rst = 1'b0;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_cap_ready", 32'(cap_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        send_tile();
        check("mid_rst_restart_row", 32'(m_row), 32'd0);
        check("mid_rst_restart_col", 32'(m_col), 32'd0);
        wait_drain("mid_rst");
        check_rx_seq("mid_rst");

        repeat (2) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
